// File: rtl/geofence_sqrt_arbiter_if.sv
// Request/grant bus between the geofence requesters and the shared
// floor-square-root engine. The engine side is the slave modport.
interface geofence_sqrt_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 24
);
    localparam int RW = WIDTH / 2;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [RW-1:0]         root;
    logic                  busy;

    modport master (
        output req,
        output a,
        input  gnt,
        input  done,
        input  root,
        input  busy
    );

    modport slave (
        input  req,
        input  a,
        output gnt,
        output done,
        output root,
        output busy
    );
endinterface

// File: rtl/geofence_sqrt_arbiter.sv
// Shared bit-serial floor(sqrt) engine with round-robin arbitration
// between NREQ requesters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; winner is granted combinationally
// CALC  | one restoring root digit per cycle, RW cycles in total
// DONE  | root register valid, one-cycle done pulse to the owner
module geofence_sqrt_arbiter #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 24
) (
    input logic                    clk,
    input logic                    reset,
    geofence_sqrt_arbiter_if.slave bus
);
    localparam int RW = WIDTH / 2;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = ($clog2(RW) > 0) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    owner_q;
    logic [WIDTH-1:0] opnd_q;
    logic [RW+1:0]    rem_q;
    logic [RW-1:0]    q_q;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    root_q;
    logic [NREQ-1:0]  done_q;

    logic             found;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    ptr_next;
    logic [WIDTH-1:0] opnd_sel;
    logic [NREQ-1:0]  gnt_c;
    logic [NREQ-1:0]  done_nx;

    logic             load;
    logic             step;
    logic             finish;

    logic [RW+3:0]    r_ext;
    logic [RW+3:0]    t_ext;
    logic [RW+3:0]    diff;
    logic             ge;
    logic [RW+1:0]    rem_nx;
    logic [RW-1:0]    q_nx;

    // Round-robin scan: first set req bit at or above ptr, wrapping at NREQ.
    always_comb begin
        int        idx;
        logic [PW-1:0] sel;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = PW'(idx);
            if (!found && bus.req[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    // Operand mux for the winner and the rotated pointer value.
    always_comb begin
        opnd_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == PW'(i)) begin
                opnd_sel = bus.a[i*WIDTH +: WIDTH];
            end
        end
        ptr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
    end

    // Next-state and control strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One restoring iteration; widened so the compare/subtract cannot wrap.
    always_comb begin
        r_ext  = {rem_q, opnd_q[WIDTH-1 -: 2]};
        t_ext  = {2'b00, q_q, 2'b01};
        diff   = r_ext - t_ext;
        ge     = (r_ext >= t_ext);
        rem_nx = ge ? diff[RW+1:0] : r_ext[RW+1:0];
        q_nx   = {q_q[RW-2:0], ge};
    end

    // Grant is gated by reset so it drops the instant reset asserts.
    always_comb begin
        gnt_c   = '0;
        done_nx = '0;
        if (load && reset) begin
            gnt_c[winner] = 1'b1;
        end
        if (finish) begin
            done_nx[owner_q] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration bookkeeping, operand/remainder/root datapath and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            owner_q <= '0;
            opnd_q  <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            done_q  <= '0;
        end else begin
            done_q <= done_nx;
            if (load) begin
                opnd_q  <= opnd_sel;
                owner_q <= winner;
                ptr_q   <= ptr_next;
                rem_q   <= '0;
                q_q     <= '0;
                cnt_q   <= CW'(RW - 1);
            end
            if (step) begin
                opnd_q <= opnd_q << 2;
                rem_q  <= rem_nx;
                q_q    <= q_nx;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
            if (finish) begin
                root_q <= q_nx;
            end
        end
    end

    assign bus.gnt  = gnt_c;
    assign bus.done = done_q;
    assign bus.root = root_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_geofence_sqrt_arbiter.sv
// Directed bench for the shared square-root arbiter (NREQ=3, WIDTH=24).
// Inputs change 1 time unit after the rising edge, outputs are sampled
// 3 time units after the rising edge.
module tb_geofence_sqrt_arbiter;
    localparam int N = 3;
    localparam int W = 24;
    localparam int R = W / 2;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    geofence_sqrt_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

    geofence_sqrt_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int k, input logic [W-1:0] v);
        bus.a[k*W +: W] = v;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        bus.req = '0;
        bus.a   = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.req = 3'b111;
        #2;
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", bus.gnt); end
        checks++; if (bus.done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", bus.done); end
        checks++; if (bus.root !== 12'd0) begin errors++; $display("FAIL reset_root: got %0d expected 0", bus.root); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        bus.req = '0;
        tick();
        reset = 1'b1;
        #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single();
        tick();
        bus.req = 3'b001;
        set_a(0, 24'd1000000);
        #2;
        checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b expected 001", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_c0: got %b expected 0", bus.busy); end
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) bus.req = '0;
            #2;
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy c%0d: got %b expected 1", c, bus.busy); end
            checks++; if (bus.done !== ((c == 13) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL single_done c%0d: got %b expected %b", c, bus.done, (c == 13) ? 3'b001 : 3'b000); end
            if (c == 13) begin
                checks++; if (bus.root !== 12'd1000) begin errors++; $display("FAIL single_root: got %0d expected 1000", bus.root); end
            end
        end
        for (int c = 14; c <= 16; c++) begin
            tick();
            #2;
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy c%0d: got %b expected 0", c, bus.busy); end
            checks++; if (bus.done !== 3'b000) begin errors++; $display("FAIL single_idle_done c%0d: got %b expected 000", c, bus.done); end
            checks++; if (bus.root !== 12'd1000) begin errors++; $display("FAIL single_root_hold c%0d: got %0d expected 1000", c, bus.root); end
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] vals  [5];
        logic [R-1:0] roots [5];
        vals  = '{24'd0, 24'd1, 24'd16769025, 24'd16769024, 24'd16777215};
        roots = '{12'd0, 12'd1, 12'd4095, 12'd4094, 12'd4095};
        for (int v = 0; v < 5; v++) begin
            tick();
            bus.req = 3'b010;
            set_a(1, vals[v]);
            #2;
            checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL bound_gnt a=%0d: got %b expected 010", vals[v], bus.gnt); end
            for (int c = 1; c <= 13; c++) begin
                tick();
                if (c == 1) bus.req = '0;
                #2;
                if (c == 13) begin
                    checks++; if (bus.done !== 3'b010) begin errors++; $display("FAIL bound_done a=%0d: got %b expected 010", vals[v], bus.done); end
                    checks++; if (bus.root !== roots[v]) begin errors++; $display("FAIL bound_root a=%0d: got %0d expected %0d", vals[v], bus.root, roots[v]); end
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_g;
        logic [2:0] exp_d;
        logic [2:0] last_g;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        last_g = '0;
        for (int cyc = 0; cyc < 42; cyc++) begin
            tick();
            if (cyc == 0) begin
                bus.req = 3'b111;
                set_a(0, 24'd10000);
                set_a(1, 24'd40000);
                set_a(2, 24'd90000);
            end else begin
                bus.req = bus.req & ~last_g;
            end
            #2;
            exp_g = (cyc % 14 == 0) ? (3'b001 << (cyc / 14)) : 3'b000;
            exp_d = (cyc % 14 == 13) ? (3'b001 << (cyc / 14)) : 3'b000;
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL contention_gnt c%0d: got %b expected %b", cyc, bus.gnt, exp_g); end
            checks++; if (bus.done !== exp_d) begin errors++; $display("FAIL contention_done c%0d: got %b expected %b", cyc, bus.done, exp_d); end
            if (cyc % 14 == 13) begin
                checks++; if (bus.root !== 12'(100 * (cyc / 14 + 1))) begin errors++; $display("FAIL contention_root c%0d: got %0d expected %0d", cyc, bus.root, 100 * (cyc / 14 + 1)); end
            end
            last_g = exp_g;
        end
    endtask

    task automatic test_fairness();
        int         seq [6];
        logic [2:0] exp_g;
        logic [2:0] exp_d;
        seq = '{0, 2, 0, 1, 2, 0};
        for (int cyc = 0; cyc < 84; cyc++) begin
            tick();
            if (cyc == 0)  bus.req = 3'b101;
            if (cyc == 30) bus.req[1] = 1'b1;
            if (cyc == 43) bus.req[1] = 1'b0;
            if (cyc == 71) bus.req = 3'b000;
            #2;
            exp_g = (cyc % 14 == 0) ? (3'b001 << seq[cyc / 14]) : 3'b000;
            exp_d = (cyc % 14 == 13) ? (3'b001 << seq[cyc / 14]) : 3'b000;
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL fair_gnt c%0d: got %b expected %b", cyc, bus.gnt, exp_g); end
            checks++; if (bus.done !== exp_d) begin errors++; $display("FAIL fair_done c%0d: got %b expected %b", cyc, bus.done, exp_d); end
            if (cyc % 14 == 13) begin
                checks++; if (bus.root !== 12'(100 * (seq[cyc / 14] + 1))) begin errors++; $display("FAIL fair_root c%0d: got %0d expected %0d", cyc, bus.root, 100 * (seq[cyc / 14] + 1)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.req = 3'b001;
        set_a(0, 24'd1000000);
        #2;
        checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL midrst_gnt: got %b expected 001", bus.gnt); end
        tick();
        bus.req = '0;
        repeat (3) tick();
        tick();
        reset   = 1'b0;
        bus.req = 3'b100;
        #1;
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL midrst_gnt_cleared: got %b expected 000", bus.gnt); end
        checks++; if (bus.done !== 3'b000) begin errors++; $display("FAIL midrst_done_cleared: got %b expected 000", bus.done); end
        checks++; if (bus.root !== 12'd0) begin errors++; $display("FAIL midrst_root_cleared: got %0d expected 0", bus.root); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_cleared: got %b expected 0", bus.busy); end
        tick();
        #2;
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL midrst_gnt_held: got %b expected 000", bus.gnt); end
        tick();
        reset = 1'b1;
        #2;
        checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL midrst_after_gnt: got %b expected 100", bus.gnt); end
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) bus.req = '0;
            #2;
            checks++; if (bus.done !== ((c == 13) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL midrst_done c%0d: got %b expected %b", c, bus.done, (c == 13) ? 3'b100 : 3'b000); end
            if (c == 13) begin
                checks++; if (bus.root !== 12'd300) begin errors++; $display("FAIL midrst_root: got %0d expected 300", bus.root); end
            end
        end
        tick();
        bus.req = 3'b111;
        #2;
        checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL midrst_ptr_gnt: got %b expected 001", bus.gnt); end
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) bus.req = '0;
            #2;
            if (c == 13) begin
                checks++; if (bus.done !== 3'b001) begin errors++; $display("FAIL midrst_ptr_done: got %b expected 001", bus.done); end
                checks++; if (bus.root !== 12'd1000) begin errors++; $display("FAIL midrst_ptr_root: got %0d expected 1000", bus.root); end
            end
        end
    endtask

    task automatic test_withdrawn();
        logic [2:0] exp_g;
        logic [2:0] exp_d;
        logic       exp_b;
        for (int cyc = 0; cyc < 32; cyc++) begin
            tick();
            case (cyc)
                0:  begin bus.req = 3'b001; set_a(0, 24'd10000); end
                1:  bus.req = 3'b000;
                3:  begin bus.req = 3'b010; set_a(1, 24'd40000); end
                4:  bus.req = 3'b000;
                16: begin bus.req = 3'b100; set_a(2, 24'd90000); end
                17: bus.req = 3'b000;
                default: ;
            endcase
            #2;
            exp_g = (cyc == 0) ? 3'b001 : (cyc == 16) ? 3'b100 : 3'b000;
            exp_d = (cyc == 13) ? 3'b001 : (cyc == 29) ? 3'b100 : 3'b000;
            exp_b = ((cyc >= 1) && (cyc <= 13)) || ((cyc >= 17) && (cyc <= 29));
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL withdraw_gnt c%0d: got %b expected %b", cyc, bus.gnt, exp_g); end
            checks++; if (bus.done !== exp_d) begin errors++; $display("FAIL withdraw_done c%0d: got %b expected %b", cyc, bus.done, exp_d); end
            checks++; if (bus.busy !== exp_b) begin errors++; $display("FAIL withdraw_busy c%0d: got %b expected %b", cyc, bus.busy, exp_b); end
            if (cyc == 13) begin
                checks++; if (bus.root !== 12'd100) begin errors++; $display("FAIL withdraw_root0: got %0d expected 100", bus.root); end
            end
            if (cyc == 29) begin
                checks++; if (bus.root !== 12'd300) begin errors++; $display("FAIL withdraw_root2: got %0d expected 300", bus.root); end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_boundaries();
        test_contention();
        test_fairness();
        test_reset_mid();
        test_withdrawn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/geofence_sqrt_arbiter.md
# geofence_sqrt_arbiter

Shared integer square-root engine for the geofence datapath. The block arbitrates one bit-serial floor-square-root unit between NREQ requesters using round-robin arbitration. Typical requesters are the edge-length calculation, the Heron semi-perimeter product, and the radius-distance check. Each requester presents a radicand with a req/gnt handshake and receives the root with a one-cycle done pulse. This replaces per-engine DW_sqrt instances with one sequenced resource.

## Interface
- NREQ, 3, number of requesters (2..8)
- WIDTH, 24, radicand width in bits (even)
- RW, WIDTH/2, root width (derived, not overridable)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; clears all state immediately
- req  in  NREQ  per-requester request level
- a  in  NREQ*WIDTH  packed radicands, requester k at bits [k*WIDTH +: WIDTH], unsigned
- gnt  out  NREQ  one-hot grant; operand of the granted requester is captured this cycle
- done  out  NREQ  one-hot, one-cycle pulse to the owning requester when root is valid
- root  out  RW  floor(sqrt(a)) of the most recently completed request
- busy  out  1  high whenever the engine is not IDLE

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the winner: the first set req bit scanning from pointer ptr upward, modulo NREQ.
  - gnt[winner] is driven combinationally in the same cycle.
  - On the clock edge, latch a[winner] into the operand shift register, record owner=winner, set ptr=(winner+1) mod NREQ, clear rem and q, load iteration counter to RW-1, and go to CALC.
- CALC: one iteration per cycle, restoring digit-by-digit:
  - r' = {rem, top 2 bits of operand}
  - t = {q, 2'b01}
  - If r' >= t: rem = r' - t, q = {q, 1}. Else: rem = r', q = {q, 0}.
  - Shift the operand left by 2.
  - rem is RW+2 bits wide and q is RW bits wide; no intermediate overflow is permitted.
  - When the counter reaches 0, go to DONE.
- DONE:
  - root <= q is registered on entry, so root is valid in the DONE cycle.
  - done[owner] = 1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- root holds its value until the next DONE. It is not cleared in IDLE.
- req is sampled only in IDLE.
  - Requests arriving during CALC/DONE wait.
  - A requester deasserting req before it is granted simply withdraws; nothing is recorded.
- Requesters must hold req and a stable until they see gnt, and must drop req the cycle after gnt unless they want another operation.
- A requester may re-request immediately. It is then queued behind the others by the ptr rotation.
- Reset mid-operation: the in-flight result is discarded and no done is issued. ptr returns to 0.

## Timing
- Reset values:
  - Outputs: gnt=0, done=0, root=0, busy=0.
  - Internal: state=IDLE, ptr=0, owner=0.
- Latency, with gnt in cycle 0:
  - CALC occupies cycles 1..RW.
  - DONE in cycle RW+1; this is 13 for the default parameters.
  - IDLE in cycle RW+2, so the earliest next gnt is at cycle RW+2 (14).
- Throughput: one root per RW+2 cycles.
- busy is 1 from cycle 1 through RW+1, and 0 in the gnt cycle (IDLE).
- gnt is combinational from req, ptr and state. done and root are registered.
- Simultaneous requests with ptr=0: priority order is 0, 1, …, NREQ-1, then the pointer rotates past each winner.

## Test plan
- Single request: reset released, req[0]=1, a[0]=1000000 → gnt[0] in cycle 0, busy high in cycles 1–13, done[0] in cycle 13 with root=1000. root stays 1000 afterwards.
- Boundaries, each on requester 1:
  - a=0 → root=0
  - a=1 → root=1
  - a=16769025 → root=4095
  - a=16769024 → root=4094
  - a=16777215 → root=4095
- Contention: req=3'b111 held from the same cycle with a={90000, 40000, 10000} for requesters {2,1,0} → grants to 0, 1, 2 at cycles 0, 14, 28 → roots 100, 200, 300 with matching done bits.
- Round-robin fairness: req[0] and req[2] held continuously → grant sequence 0, 2, 0, 2…. Requester 1 raised later is served before 0 whenever ptr points at 1.
- Reset mid-CALC: assert reset in cycle 5 of a request → gnt, done, root and busy are 0 immediately, with no done pulse. After release, req[2] alone is granted; the next simultaneous req=3'b111 grants 0 first (ptr=0).
- Withdrawn request: req[1] pulsed for one cycle while busy → never granted, no done[1]. Other traffic is unaffected.
